// File: rtl/knn_scheduler.sv
// KNN run scheduler: sequences fetch / distance / report over
// N data points for each of S test points.
module knn_scheduler #(
    parameter int N   = 10,
    parameter int S   = 16,
    parameter int N_W = $clog2(N),
    parameter int S_W = $clog2(S)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           mem_req,
    output logic [N_W-1:0] mem_addr,
    input  logic           mem_ack,
    output logic [S_W-1:0] test_idx,
    output logic           nb_clr,
    output logic           en_dist,
    input  logic           dist_done,
    output logic           res_valid,
    input  logic           res_ack,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_CALC,
        ST_WAIT,
        ST_REPORT,
        ST_DONE
    } state_t;

    state_t         state, state_nx;
    logic [N_W-1:0] data_idx;
    logic [S_W-1:0] test_q;
    logic           data_last;
    logic           test_last;

    assign data_last = (data_idx == N_W'(N - 1));
    assign test_last = (test_q == S_W'(S - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Counters advance only on the handshake that leaves their state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_idx <= '0;
            test_q   <= '0;
        end else if (abort) begin
            data_idx <= '0;
            test_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    data_idx <= '0;
                    test_q   <= '0;
                end
                ST_CLEAR: data_idx <= '0;
                ST_WAIT: if (dist_done && !data_last)
                    data_idx <= data_idx + N_W'(1);
                ST_REPORT: if (res_ack && !test_last)
                    test_q <= test_q + S_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (start) state_nx = ST_CLEAR;
                ST_CLEAR:  state_nx = ST_FETCH;
                ST_FETCH:  if (mem_ack) state_nx = ST_CALC;
                ST_CALC:   state_nx = ST_WAIT;
                ST_WAIT: if (dist_done)
                    state_nx = data_last ? ST_REPORT : ST_FETCH;
                ST_REPORT: if (res_ack)
                    state_nx = test_last ? ST_DONE : ST_CLEAR;
                ST_DONE:   state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        nb_clr    = 1'b0;
        en_dist   = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        unique case (state)
            ST_CLEAR:  nb_clr    = 1'b1;
            ST_FETCH:  mem_req   = 1'b1;
            ST_CALC:   en_dist   = 1'b1;
            ST_REPORT: res_valid = 1'b1;
            ST_DONE:   done      = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = data_idx;
    assign test_idx = test_q;

endmodule

// File: tb/tb_knn_scheduler.sv
// Directed bench for knn_scheduler: timing, stalls, abort,
// reset and spurious-handshake scenarios.
module tb_knn_scheduler;

    localparam int N   = 10;
    localparam int S   = 16;
    localparam int N_W = $clog2(N);
    localparam int S_W = $clog2(S);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           mem_req;
    logic [N_W-1:0] mem_addr;
    logic           mem_ack = 1'b0;
    logic [S_W-1:0] test_idx;
    logic           nb_clr;
    logic           en_dist;
    logic           dist_done = 1'b0;
    logic           res_valid;
    logic           res_ack = 1'b0;
    logic           busy;
    logic           done;

    int n_cmp = 0;
    int n_err = 0;
    int mem_delay = 0;
    int res_hold = 0;

    knn_scheduler #(.N(N), .S(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .test_idx(test_idx), .nb_clr(nb_clr), .en_dist(en_dist),
        .dist_done(dist_done), .res_valid(res_valid),
        .res_ack(res_ack), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [N_W+S_W+5:0] outs();
        return {mem_req, mem_addr, test_idx, nb_clr,
                en_dist, res_valid, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then plays the handshake model until done.
    task automatic run_to_done(input int limit, output int dcyc,
                               output int nclr, output int nen,
                               output int rv0);
        int  cyc, fcnt, rcnt;
        logic [N_W-1:0] prev_addr;
        logic prev_ack, waiting, acked;
        dcyc = -1; nclr = 0; nen = 0; rv0 = 0;
        fcnt = 0; rcnt = 0; prev_ack = 1'b0;
        waiting = 1'b0; acked = 1'b0; prev_addr = '0;
        dist_done = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc <= limit) begin
            if (nb_clr) nclr++;
            if (nb_clr && waiting) begin
                n_cmp++;
                n_err++;
                $display("FAIL nb_clr_during_hold: nb_clr=1 required 0 cyc=%0d", cyc);
            end
            if (en_dist) begin
                n_cmp++;
                if (mem_addr !== N_W'(nen % N) ||
                    test_idx !== S_W'(nen / N)) begin
                    n_err++;
                    $display("FAIL addr_seq: addr=%0d tidx=%0d required %0d %0d",
                             mem_addr, test_idx, nen % N, nen / N);
                end
                if (mem_delay > 0) begin
                    n_cmp++;
                    if (!prev_ack) begin
                        n_err++;
                        $display("FAIL en_before_ack: en_dist=1 required 0 cyc=%0d", cyc);
                    end
                end
                nen++;
            end
            if (mem_req) begin
                fcnt++;
                if (fcnt > 1) begin
                    n_cmp++;
                    if (mem_addr !== prev_addr) begin
                        n_err++;
                        $display("FAIL addr_stable: addr=%0d required %0d",
                                 mem_addr, prev_addr);
                    end
                end
                prev_addr = mem_addr;
                mem_ack = (mem_delay == 0) || (fcnt > mem_delay);
            end else begin
                fcnt = 0;
                mem_ack = (mem_delay == 0);
            end
            prev_ack = mem_ack && mem_req;
            if (res_valid && test_idx == '0 && !acked) begin
                rcnt++;
                rv0++;
                res_ack = (rcnt > res_hold);
                waiting = !res_ack;
                acked = res_ack;
            end else begin
                res_ack = 1'b1;
            end
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        res_ack = 1'b0;
        mem_ack = 1'b0;
        dist_done = 1'b0;
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %h required 0", outs());
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_int("idle_busy", int'(busy), 0);
    endtask

    task automatic test_nominal();
        int dc, nc, ne, rv;
        mem_delay = 0; res_hold = 0;
        run_to_done(600, dc, nc, ne, rv);
        check_int("nom_done_cyc", dc, 513);
        check_int("nom_nb_clr", nc, 16);
        check_int("nom_en_dist", ne, 160);
        tick();
        check_int("nom_idle", int'(busy), 0);
    endtask

    task automatic test_mem_stall();
        int dc, nc, ne, rv;
        mem_delay = 3; res_hold = 0;
        run_to_done(1100, dc, nc, ne, rv);
        check_int("stall_done_cyc", dc, 993);
        check_int("stall_en_dist", ne, 160);
        mem_delay = 0;
        tick();
    endtask

    task automatic test_report_stall();
        int dc, nc, ne, rv;
        mem_delay = 0; res_hold = 5;
        run_to_done(600, dc, nc, ne, rv);
        check_int("rpt_valid_cycles", rv, 6);
        check_int("rpt_done_cyc", dc, 518);
        check_int("rpt_nb_clr", nc, 16);
        res_hold = 0;
        tick();
    endtask

    task automatic test_abort();
        int dc, nc, ne, rv;
        bit found = 0;
        mem_ack = 1'b1; dist_done = 1'b1; res_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (en_dist && mem_addr == 4 && test_idx == 2) begin
                found = 1;
                break;
            end
            tick();
        end
        check_int("abort_found", int'(found), 1);
        tick();
        check_int("abort_in_wait", int'(mem_req || en_dist), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || mem_addr !== '0 ||
            test_idx !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b addr=%0d tidx=%0d done=%b required 0 0 0 0",
                     busy, mem_addr, test_idx, done);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_done: done=%b busy=%b required 0 0", done, busy);
            end
            tick();
        end
        run_to_done(600, dc, nc, ne, rv);
        check_int("abort_rerun_cyc", dc, 513);
        tick();
    endtask

    task automatic test_rst_mid_run();
        mem_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_int("rst_in_fetch", int'(mem_req), 1);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL rst_async: got %h required 0", outs());
        end
        start = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        start = 1'b0;
        check_int("rst_first_start", int'(nb_clr && busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_int("rst_abort_idle", int'(busy), 0);
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_int("start_abort_busy", int'(busy), 0);
        tick();
        check_int("start_abort_busy2", int'(busy), 0);
    endtask

    task automatic test_spurious();
        mem_ack = 1'b1; dist_done = 1'b1; res_ack = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL spur_idle: got %h required 0", outs());
        end
        mem_ack = 1'b0; dist_done = 1'b0; res_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_int("spur_fetch", int'(mem_req), 1);
        mem_ack = 1'b1;
        tick();
        check_int("spur_calc", int'(en_dist), 1);
        dist_done = 1'b1; res_ack = 1'b1;
        tick();
        mem_ack = 1'b0; dist_done = 1'b0; res_ack = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0 || en_dist !== 1'b0 || busy !== 1'b1 ||
            res_valid !== 1'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL spur_calc_next: req=%b en=%b busy=%b rv=%b addr=%0d required 0 0 1 0 0",
                     mem_req, en_dist, busy, res_valid, mem_addr);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b1 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL spur_wait_hold: req=%b busy=%b addr=%0d required 0 1 0",
                     mem_req, busy, mem_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mem_stall();
        test_report_stall();
        test_abort();
        test_rst_mid_run();
        test_start_abort();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/knn_scheduler.md
KNN_SCHEDULER -- requirements
Module: knn_scheduler

Interface
REQ-001 Parameter N, default 10: number of data points per test point; N >= 2.
REQ-002 Parameter S, default 16: number of test points per run; S >= 2.
REQ-003 Parameter N_W, default $clog2(N): width of mem_addr. Parameter S_W, default $clog2(S): width of test_idx.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 start  input  1  begin a run; sampled only in IDLE.
REQ-007 abort  input  1  synchronous abort of the current run.
REQ-008 mem_req  output  1  data-point fetch request.
REQ-009 mem_addr  output  N_W  index of the data point being fetched.
REQ-010 mem_ack  input  1  fetch complete; data point valid at datapath input.
REQ-011 test_idx  output  S_W  index of the current test point.
REQ-012 nb_clr  output  1  one-cycle pulse that clears the neighbour list.
REQ-013 en_dist  output  1  one-cycle pulse that starts distance calculation and insertion.
REQ-014 dist_done  input  1  datapath has finished distance calculation and insertion.
REQ-015 res_valid  output  1  neighbour list for test_idx is final.
REQ-016 res_ack  input  1  consumer has taken the result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when the run completes.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, FETCH, CALC, WAIT, REPORT and DONE; all outputs are Moore, decoded from registered state and counters.
REQ-020 IDLE: start=1 -> CLEAR, with data_idx=0 and test_idx=0.
REQ-021 CLEAR: nb_clr=1 for exactly one cycle, data_idx cleared to 0, then -> FETCH.
REQ-022 FETCH: mem_req=1, with mem_addr stable; mem_ack=1 -> CALC; otherwise stay in FETCH and hold mem_req.
REQ-023 CALC: en_dist=1 for exactly one cycle, then -> WAIT.
REQ-024 WAIT: dist_done=1 and data_idx==N-1 -> REPORT; dist_done=1 otherwise -> data_idx+1, then -> FETCH.
REQ-025 REPORT: res_valid=1 held until res_ack=1; then -> DONE if test_idx==S-1, else test_idx+1 and -> CLEAR.
REQ-026 DONE: done=1 for one cycle, then -> IDLE.
REQ-027 mem_addr SHALL equal data_idx at all times; counters never wrap and never exceed N-1 or S-1.
REQ-028 mem_ack is ignored outside FETCH, dist_done outside WAIT, and res_ack outside REPORT.
REQ-029 start is ignored when not in IDLE.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge, clear both counters, and suppress done; abort has priority over start and over all handshakes.
REQ-031 Timing with mem_ack, dist_done and res_ack tied high: each data point takes 3 cycles, each test point takes 3N+2 cycles, and done is high in cycle S*(3N+2)+1 after the start edge.
REQ-032 Stalls add latency one-for-one; each stall cycle in FETCH, WAIT or REPORT adds one cycle.

Reset
REQ-033 While rst=0, state=IDLE, data_idx=0, test_idx=0, and all outputs are 0, independent of clk.
REQ-034 Reset asserted mid-run SHALL discard the run; after release, the block waits in IDLE for a new start.
REQ-035 The first edge after rst release SHALL honour start.

Verification
REQ-036 N=10, S=16, handshakes tied 1, start pulse -> done in cycle 513; 16 nb_clr pulses, 160 en_dist pulses; mem_addr sequence 0..9 for each test_idx 0..15.
REQ-037 mem_ack delayed 3 cycles per fetch -> mem_req and mem_addr stable while waiting, no en_dist before ack, done in cycle 993.
REQ-038 res_ack withheld 5 cycles at test_idx=0 -> res_valid high 6 cycles, test_idx stays 0, no nb_clr until the ack.
REQ-039 abort in WAIT at data_idx=4, test_idx=2 -> next cycle busy=0, mem_addr=0, test_idx=0, no done; a following start runs to done in 513 cycles.
REQ-040 rst=0 asserted in FETCH -> all outputs 0 without a clock edge; start and abort together in IDLE -> stays IDLE.
REQ-041 Spurious mem_ack, dist_done and res_ack in IDLE and CALC -> no state or counter change.
